// File: rtl/tt_usman_pkg.sv
// rtl/tt_usman_pkg.sv - shared types and pin map for the bit-serial subtractor
package tt_usman_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int WIDTH_DEF = 4;

    localparam int START_BIT  = 0;
    localparam int BORROW_BIT = 4;
    localparam int BUSY_BIT   = 5;
    localparam int DONE_BIT   = 6;
    localparam int ZERO_BIT   = 7;

endpackage

// File: rtl/serial_sub_cell.sv
// rtl/serial_sub_cell.sv - combinational one-bit full subtractor
module serial_sub_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/tt_um_usman_serial_sub.sv
// rtl/tt_um_usman_serial_sub.sv - bit-serial A-B subtractor in the Tiny Tapeout wrapper
module tt_um_usman_serial_sub
    import tt_usman_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    output logic [7:0] uo_out
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t             r_state;
    logic [WIDTH-1:0]   r_a_sr;
    logic [WIDTH-1:0]   r_b_sr;
    logic [WIDTH-1:0]   r_sr;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_br;
    logic               r_s1;
    logic               r_s2;
    logic               r_s3;
    logic               r_busy;
    logic               r_done;
    logic               r_bout;
    logic               r_zero;

    logic               w_start_evt;
    logic               w_d;
    logic               w_br_next;
    logic [WIDTH-1:0]   w_sr_next;
    logic [WIDTH-1:0]   w_a_in;
    logic [WIDTH-1:0]   w_b_in;
    logic [3:0]         w_diff_pin;
    logic               w_unused;

    assign w_start_evt = r_s2 & ~r_s3;
    assign w_unused    = &{ena, uio_in[7:1], 1'b0};

    serial_sub_cell u_cell (
        .a    (r_a_sr[0]),
        .b    (r_b_sr[0]),
        .bin  (r_br),
        .d    (w_d),
        .bout (w_br_next)
    );

    // Operand nibbles and the difference nibble are fixed at four pins; other widths pad or truncate.
    always_comb begin
        w_a_in     = '0;
        w_b_in     = '0;
        w_diff_pin = '0;
        for (int i = 0; i < 4 && i < WIDTH; i++) begin
            w_a_in[i]     = ui_in[i];
            w_b_in[i]     = ui_in[4+i];
            w_diff_pin[i] = r_sr[i];
        end
    end

    always_comb begin
        w_sr_next          = r_sr >> 1;
        w_sr_next[WIDTH-1] = w_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_a_sr  <= '0;
            r_b_sr  <= '0;
            r_sr    <= '0;
            r_cnt   <= '0;
            r_br    <= 1'b0;
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_s3    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_bout  <= 1'b0;
            r_zero  <= 1'b0;
        end else begin
            r_s1 <= uio_in[START_BIT];
            r_s2 <= r_s1;
            r_s3 <= r_s2;
            case (r_state)
                IDLE, DONE: begin
                    if (w_start_evt) begin
                        r_a_sr  <= w_a_in;
                        r_b_sr  <= w_b_in;
                        r_br    <= 1'b0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_bout  <= 1'b0;
                        r_zero  <= 1'b0;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_sr   <= w_sr_next;
                    r_a_sr <= r_a_sr >> 1;
                    r_b_sr <= r_b_sr >> 1;
                    r_br   <= w_br_next;
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_bout  <= w_br_next;
                        r_zero  <= (w_sr_next == '0);
                        r_state <= DONE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign uo_out[3:0]        = w_diff_pin;
    assign uo_out[BORROW_BIT] = r_bout;
    assign uo_out[BUSY_BIT]   = r_busy;
    assign uo_out[DONE_BIT]   = r_done;
    assign uo_out[ZERO_BIT]   = r_zero;
    assign uio_out            = 8'h00;
    assign uio_oe             = 8'h00;

endmodule

// File: tb/tb_tt_um_usman_serial_sub.sv
// tb/tb_tt_um_usman_serial_sub.sv - self-checking bench for the serial subtractor
module tb_tt_um_usman_serial_sub;

    localparam int MODE_PULSE    = 0;
    localparam int MODE_HOLD     = 1;
    localparam int MODE_REPULSE  = 2;
    localparam int MODE_SCRAMBLE = 3;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    logic [7:0] uo_out;

    int checks;
    int failures;

    tt_um_usman_serial_sub dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe),
        .uo_out  (uo_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain unsigned arithmetic, no knowledge of the serial datapath.
    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input int mode, input string tag);
        int n;
        int n_done;
        int n_busy_first;
        int busy_cycles;
        int exp_diff;
        bit uio_bad;
        bit done_at_capture;
        exp_diff = (int'(a) - int'(b)) & 15;
        n_done = 0;
        n_busy_first = 0;
        busy_cycles = 0;
        uio_bad = 1'b0;
        done_at_capture = 1'b1;
        uio_in[0] = 1'b0;
        repeat (3) @(negedge clk);
        ui_in = {b, a};
        uio_in[0] = 1'b1;
        for (n = 1; n <= 24; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (uo_out[5]) begin
                busy_cycles++;
                if (n_busy_first == 0) begin
                    n_busy_first = n;
                    done_at_capture = uo_out[6];
                end
            end
            if (uo_out[6] && n_done == 0 && n_busy_first != 0) n_done = n;
            if (uio_oe !== 8'h00 || uio_out !== 8'h00) uio_bad = 1'b1;
            if (mode == MODE_HOLD) begin
                if (n == 20) uio_in[0] = 1'b0;
            end else if (mode == MODE_REPULSE) begin
                uio_in[0] = (n == 3);
            end else begin
                uio_in[0] = 1'b0;
            end
            if (mode == MODE_SCRAMBLE && n >= 3) ui_in = 8'($urandom);
        end
        check_val({tag, "_busy_lat"}, n_busy_first - 1, 2);
        check_val({tag, "_done_lat"}, n_done - 1, 6);
        check_val({tag, "_busy_len"}, busy_cycles, 4);
        check_val({tag, "_done_cap"}, done_at_capture, 0);
        check_val({tag, "_diff"}, uo_out[3:0], exp_diff);
        check_val({tag, "_borrow"}, uo_out[4], (a < b) ? 1 : 0);
        check_val({tag, "_zero"}, uo_out[7], (exp_diff == 0) ? 1 : 0);
        check_val({tag, "_flags"}, uo_out[6:5], 2'b10);
        check_val({tag, "_uio"}, uio_bad, 0);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        ena = 1'b1;
        rst_n = 1'b0;
        ui_in = 8'h00;
        uio_in = 8'h00;
        repeat (2) @(negedge clk);
        check_val("reset_uo", uo_out, 8'h00);
        check_val("reset_uio", {uio_oe, uio_out}, 16'h0000);
        rst_n = 1'b1;

        run_op(4'd9, 4'd3, MODE_PULSE, "t1");
        run_op(4'd3, 4'd9, MODE_PULSE, "t2");
        run_op(4'd5, 4'd5, MODE_PULSE, "t3a");
        run_op(4'd0, 4'd15, MODE_PULSE, "t3b");
        run_op(4'd12, 4'd4, MODE_HOLD, "t4a");
        run_op(4'd12, 4'd4, MODE_REPULSE, "t4b");

        // Reset two shift cycles into an operation.
        uio_in[0] = 1'b0;
        repeat (3) @(negedge clk);
        ui_in = {4'd15, 4'd6};
        uio_in[0] = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            @(posedge clk);
            @(negedge clk);
            uio_in[0] = 1'b0;
        end
        check_val("t5_busy_before", uo_out[5], 1);
        rst_n = 1'b0;
        #1;
        check_val("t5_async_clear", uo_out, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check_val("t5_idle_after", uo_out, 8'h00);
        run_op(4'd7, 4'd2, MODE_PULSE, "t5");

        run_op(4'd10, 4'd1, MODE_SCRAMBLE, "t6");

        for (int i = 0; i < 12; i++) begin
            run_op(4'($urandom), 4'($urandom), (i % 2 == 0) ? MODE_PULSE : MODE_SCRAMBLE, "rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
